// File: rtl/bcd_down_counter_pkg.sv
// Shared definitions for the BCD down-counter: state encoding, digit limits
// and helpers for turning arbitrary load values into legal BCD.
package bcd_down_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX           = 4'd9;
  localparam int         DIV_WIDTH_DEFAULT = 27;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  // Each nibble is clamped on its own, so 8'hAF becomes 8'h99.
  function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
    return {clamp_digit(v[7:4]), clamp_digit(v[3:0])};
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Combinational single-digit BCD decrementer with borrow chaining.
// A borrow into digit 0 wraps to BCD_MAX and propagates the borrow onward.
module bcd_digit_dec
  import bcd_down_counter_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] next_digit,
  output logic       borrow_out
);

  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        next_digit = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Two-digit BCD countdown timer with a prescaler-based clock enable,
// load-priority control and a single-cycle done pulse on expiry.
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic [7:0] q,
  output logic       running,
  output logic       zero,
  output logic       done
);

  state_t               r_state;
  state_t               w_state_next;
  logic [7:0]           r_q;
  logic [7:0]           w_q_next;
  logic [DIV_WIDTH-1:0] r_presc;
  logic [DIV_WIDTH-1:0] w_presc_next;
  logic                 r_done;
  logic                 w_done_next;

  logic                 w_tick;
  logic [7:0]           w_load_clamped;
  logic [3:0]           w_ones_dec;
  logic [3:0]           w_tens_dec;
  logic                 w_ones_borrow;
  logic                 w_tens_borrow;
  logic [7:0]           w_q_dec;

  assign w_tick         = (r_state == ST_RUN) && en && (&r_presc);
  assign w_load_clamped = clamp_bcd(load_val);

  bcd_digit_dec u_ones (
    .digit      (r_q[3:0]),
    .borrow_in  (w_tick),
    .next_digit (w_ones_dec),
    .borrow_out (w_ones_borrow)
  );

  bcd_digit_dec u_tens (
    .digit      (r_q[7:4]),
    .borrow_in  (w_ones_borrow),
    .next_digit (w_tens_dec),
    .borrow_out (w_tens_borrow)
  );

  assign w_q_dec = {w_tens_dec, w_ones_dec};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_q     <= 8'h00;
      r_presc <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_presc <= w_presc_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_presc_next = r_presc;
    w_done_next  = 1'b0;
    if (load) begin
      w_q_next     = w_load_clamped;
      w_presc_next = '0;
      w_state_next = (w_load_clamped != 8'h00) ? ST_RUN : ST_EXPIRED;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (en) begin
            w_presc_next = r_presc + DIV_WIDTH'(1);
            if (w_tick) begin
              // A tens underflow cannot occur from a nonzero count; treat it as expiry anyway.
              if (w_tens_borrow || (w_q_dec == 8'h00)) begin
                w_q_next     = 8'h00;
                w_state_next = ST_EXPIRED;
                w_done_next  = 1'b1;
              end else begin
                w_q_next = w_q_dec;
              end
            end
          end
        end
        ST_EXPIRED: w_q_next = 8'h00;
        ST_IDLE:    w_q_next = r_q;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  assign q       = r_q;
  assign running = (r_state == ST_RUN);
  assign zero    = (r_q == 8'h00);
  assign done    = r_done;

endmodule
